// File: rtl/aes_key_word_sender_if.sv
// Request and key-word stream bundle for aes_key_word_sender.
// The slave modport is the sender; the master modport is the requester/AES side.
interface aes_key_word_sender_if;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_key;
  logic [1:0]   in_size_cfg;
  logic         in_inverse;
  logic         out_key_valid;
  logic         out_key_ready;
  logic [31:0]  out_key_data;
  logic [1:0]   out_key_size_cfg;
  logic         out_key_mode_inverse;
  logic         busy;
  logic         err_cfg;

  modport master (
    output in_valid, in_key, in_size_cfg, in_inverse, out_key_ready,
    input  in_ready, out_key_valid, out_key_data, out_key_size_cfg,
           out_key_mode_inverse, busy, err_cfg
  );

  modport slave (
    input  in_valid, in_key, in_size_cfg, in_inverse, out_key_ready,
    output in_ready, out_key_valid, out_key_data, out_key_size_cfg,
           out_key_mode_inverse, busy, err_cfg
  );
endinterface

// File: rtl/aes_key_word_sender.sv
// Serialises a 128/192/256-bit key into 32-bit words for the masked AES key stream.
// The key copy is shifted down one word per handshake and zeroed after the last word.
module aes_key_word_sender (
  input  logic                  clk,
  input  logic                  rst,
  aes_key_word_sender_if.slave  kif
);
  localparam int unsigned WORD_W = 32;
  localparam int unsigned KEY_W  = 256;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned CFG_W  = 2;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic [CFG_W-1:0] CFG_128 = 2'b00;
  localparam logic [CFG_W-1:0] CFG_192 = 2'b01;
  localparam logic [CFG_W-1:0] CFG_BAD = 2'b11;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [CFG_W-1:0] size_q, size_d;
  logic             inv_q, inv_d;
  logic             in_ready_q, in_ready_d;
  logic             err_q, err_d;

  logic             accept;
  logic             legal;
  logic             take;
  logic             last;
  logic [CNT_W-1:0] last_idx;

  assign accept   = kif.in_valid & in_ready_q;
  assign legal    = (kif.in_size_cfg != CFG_BAD);
  assign take     = (state_q == SEND) & kif.out_key_ready;
  assign last_idx = (size_q == CFG_128) ? 3'd3 :
                    (size_q == CFG_192) ? 3'd5 : 3'd7;
  assign last     = (cnt_q == last_idx);

  // Next-state and register-input logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    size_d  = size_q;
    inv_d   = inv_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && legal) begin
          state_d = SEND;
          key_d   = kif.in_key;
          size_d  = kif.in_size_cfg;
          inv_d   = kif.in_inverse;
          cnt_d   = '0;
        end else if (accept) begin
          err_d   = 1'b1;
        end
      end
      SEND: begin
        if (take) begin
          if (last) begin
            state_d = IDLE;
            key_d   = '0;
            cnt_d   = '0;
            size_d  = '0;
            inv_d   = 1'b0;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            key_d   = key_q >> WORD_W;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      key_q      <= '0;
      size_q     <= '0;
      inv_q      <= 1'b0;
      in_ready_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_q      <= key_d;
      size_q     <= size_d;
      inv_q      <= inv_d;
      in_ready_q <= in_ready_d;
      err_q      <= err_d;
    end
  end

  // Current word always sits in the bottom slot of the shifted key copy.
  assign kif.in_ready             = in_ready_q;
  assign kif.out_key_valid        = (state_q == SEND);
  assign kif.busy                 = (state_q == SEND);
  assign kif.out_key_data         = key_q[WORD_W-1:0];
  assign kif.out_key_size_cfg     = size_q;
  assign kif.out_key_mode_inverse = inv_q;
  assign kif.err_cfg              = err_q;
endmodule
